// File: rtl/system_0_nios2_qsys_0_oci_monitor_mem.sv
`default_nettype none
// ============================================================================
// Module   : system_0_nios2_qsys_0_oci_monitor_mem
// Purpose  : Nios II OCI debug monitor RAM with JTAG access sequencer and a
//            CPU Avalon-MM slave port that always has priority over JTAG.
// Revision : 1.0 - initial release
// ============================================================================
module system_0_nios2_qsys_0_oci_monitor_mem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PEND_RD = 2'd1;
    localparam logic [1:0] S_PEND_WR = 2'd2;
    localparam logic [1:0] S_RD_DATA = 2'd3;
    localparam int         DEPTH     = 1 << ADDR_W;

    logic [1:0]        state_q, state_d;
    logic              region_q, region_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [31:0]       mon_dreg_q, mon_dreg_d;
    logic              ready_q, ready_d;
    logic              error_q, error_d;
    logic              rd_phase_q, rd_phase_d;

    logic              cpu_req, cpu_wr, cpu_rd, any_strobe;
    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic [31:0]       ram_q;
    logic [31:0]       mem [DEPTH];

    logic              unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    // read+write together counts as a write
    assign cpu_req    = chipselect & (read | write);
    assign cpu_wr     = cpu_req & write;
    assign cpu_rd     = cpu_req & ~write;
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_action_ocimem_b)
                    state_d = S_PEND_WR;
                else if (take_action_ocimem_a || take_no_action_ocimem_a)
                    state_d = S_PEND_RD;
            end
            S_PEND_RD: if (!cpu_req) state_d = region_q ? S_IDLE : S_RD_DATA;
            S_PEND_WR: if (!cpu_req) state_d = S_IDLE;
            S_RD_DATA: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        region_d   = region_q;
        word_d     = word_q;
        mon_dreg_d = mon_dreg_q;
        ready_d    = ready_q;
        error_d    = error_q;
        rd_phase_d = cpu_rd & ~rd_phase_q;
        ram_we     = cpu_wr;
        ram_re     = cpu_rd & ~rd_phase_q;
        ram_addr   = address;
        ram_wdata  = writedata;
        ram_be     = byteenable;

        case (state_q)
            S_IDLE: begin
                if (take_action_ocimem_b) begin
                    mon_dreg_d = jdo[34:3];
                    ready_d    = 1'b0;
                end else if (take_action_ocimem_a) begin
                    region_d = jdo[25];
                    word_d   = jdo[17 +: ADDR_W];
                    error_d  = 1'b0;
                    ready_d  = 1'b0;
                end else if (take_no_action_ocimem_a) begin
                    word_d  = word_q + ADDR_W'(1);
                    ready_d = 1'b0;
                end
            end
            S_PEND_RD: begin
                if (!cpu_req) begin
                    if (region_q) begin
                        mon_dreg_d = '0;
                        error_d    = 1'b1;
                        ready_d    = 1'b1;
                    end else begin
                        ram_re   = 1'b1;
                        ram_addr = word_q;
                    end
                end
            end
            S_PEND_WR: begin
                if (!cpu_req) begin
                    if (region_q) begin
                        error_d = 1'b1;
                    end else begin
                        ram_we    = 1'b1;
                        ram_addr  = word_q;
                        ram_wdata = mon_dreg_q;
                        ram_be    = 4'hF;
                    end
                    word_d  = word_q + ADDR_W'(1);
                    ready_d = 1'b1;
                end
            end
            S_RD_DATA: begin
                mon_dreg_d = ram_q;
                ready_d    = 1'b1;
            end
            default: ;
        endcase

        // a strobe while busy is dropped but flagged
        if ((state_q != S_IDLE) && any_strobe)
            error_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            region_q   <= 1'b0;
            word_q     <= '0;
            mon_dreg_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rd_phase_q <= 1'b0;
        end else begin
            region_q   <= region_d;
            word_q     <= word_d;
            mon_dreg_q <= mon_dreg_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            rd_phase_q <= rd_phase_d;
        end
    end

    // single-port RAM; output register only moves on an issued read
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_addr];
    end

    assign waitrequest   = cpu_rd & ~rd_phase_q;
    assign readdata      = rd_phase_q ? ram_q : 32'h0;
    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_system_0_nios2_qsys_0_oci_monitor_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_system_0_nios2_qsys_0_oci_monitor_mem
// Purpose  : Self-checking bench for the OCI monitor RAM and JTAG sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_system_0_nios2_qsys_0_oci_monitor_mem;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: memory image plus the JTAG-visible registers
    logic [31:0] model_mem [DEPTH];
    logic        model_region;
    logic [7:0]  model_word;
    logic [31:0] model_dreg;
    logic        model_err;

    always #5 clk = ~clk;

    system_0_nios2_qsys_0_oci_monitor_mem #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .address                 (address),
        .chipselect              (chipselect),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .byteenable              (byteenable),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [8:0] a);
        logic [37:0] j;
        j[31:0]  = $urandom;
        j[37:32] = 6'($urandom);
        j[25:17] = a;
        return j;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] j;
        j[31:0]  = $urandom;
        j[37:32] = 6'($urandom);
        j[34:3]  = d;
        return j;
    endfunction

    task automatic model_cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // kind: 0 = load address + read, 1 = next address + read, 2 = write + next address
    task automatic model_cmd(input int kind, input logic [37:0] j, output int lat);
        if (kind == 2) begin
            model_dreg = j[34:3];
            if (model_region) model_err = 1'b1;
            else              model_mem[model_word] = model_dreg;
            model_word = model_word + 8'd1;
            lat = 2;
        end else begin
            if (kind == 0) begin
                model_region = j[25];
                model_word   = j[24:17];
                model_err    = 1'b0;
            end else begin
                model_word = model_word + 8'd1;
            end
            if (model_region) begin
                model_dreg = 32'h0;
                model_err  = 1'b1;
                lat = 2;
            end else begin
                model_dreg = model_mem[model_word];
                lat = 3;
            end
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be, output logic w);
        address = a; writedata = d; byteenable = be; chipselect = 1'b1; write = 1'b1; read = 1'b0;
        #1;
        w = waitrequest;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits);
        address = a; chipselect = 1'b1; read = 1'b1; write = 1'b0; waits = 0;
        #1;
        while (waitrequest && waits < 10) begin
            step();
            waits++;
            #1;
        end
        d = readdata;
        step();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic jtag_issue(input int kind, input logic [37:0] j);
        jdo = j;
        take_action_ocimem_a    = (kind == 0);
        take_no_action_ocimem_a = (kind == 1);
        take_action_ocimem_b    = (kind == 2);
        step();
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    endtask

    // latency counted in cycles from the strobe cycle to the first cycle ready is seen
    task automatic wait_ready(input int start, output int lat);
        lat = start;
        while (!monitor_ready && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic jtag_run(input int kind, input logic [37:0] j, output int lat);
        jtag_issue(kind, j);
        wait_ready(1, lat);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_region = 1'b0; model_word = 8'd0; model_dreg = 32'h0; model_err = 1'b0;
        step();
        vectors++; if (MonDReg !== 32'h0) begin miscompares++; $display("FAIL reset_mondreg: got %h want 0", MonDReg); end
        vectors++; if (monitor_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", monitor_ready); end
        vectors++; if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b want 0", monitor_error); end
        vectors++; if (waitrequest !== 1'b0) begin miscompares++; $display("FAIL reset_waitrequest: got %b want 0", waitrequest); end
        vectors++; if (readdata !== 32'h0) begin miscompares++; $display("FAIL reset_readdata: got %h want 0", readdata); end
    endtask

    task automatic preload();
        logic w;
        logic [31:0] d;
        for (int a = 0; a < DEPTH; a++) begin
            d = $urandom;
            cpu_write(8'(a), d, 4'hF, w);
            model_cpu_write(8'(a), d, 4'hF);
        end
    endtask

    task automatic test_read_basic();
        logic w;
        logic [37:0] j;
        int lat, exp_lat;
        cpu_write(8'd5, 32'hCAFEF00D, 4'hF, w);
        model_cpu_write(8'd5, 32'hCAFEF00D, 4'hF);
        vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL cpu_write_wait: got %b want 0", w); end
        j = jdo_addr(9'h005);
        model_cmd(0, j, exp_lat);
        jtag_run(0, j, lat);
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL read_latency: got %0d want 3", lat); end
        vectors++; if (MonDReg !== 32'hCAFEF00D) begin miscompares++; $display("FAIL read_mondreg: got %h want cafef00d", MonDReg); end
        vectors++; if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL read_error: got %b want 0", monitor_error); end
    endtask

    task automatic test_write_wrap();
        logic [37:0] j;
        logic [31:0] d;
        int lat, exp_lat, waits;
        j = jdo_addr(9'h0FF);
        model_cmd(0, j, exp_lat);
        jtag_run(0, j, lat);
        j = jdo_data(32'h11111111);
        model_cmd(2, j, exp_lat);
        jtag_run(2, j, lat);
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL write_latency: got %0d want 2", lat); end
        j = jdo_data(32'h22222222);
        model_cmd(2, j, exp_lat);
        jtag_run(2, j, lat);
        cpu_read(8'd255, d, waits);
        vectors++; if (d !== 32'h11111111) begin miscompares++; $display("FAIL wrap_word255: got %h want 11111111", d); end
        cpu_read(8'd0, d, waits);
        vectors++; if (d !== 32'h22222222) begin miscompares++; $display("FAIL wrap_word0: got %h want 22222222", d); end
        vectors++; if (waits != 1) begin miscompares++; $display("FAIL cpu_read_waits: got %0d want 1", waits); end
    endtask

    task automatic test_cpu_stall();
        logic [37:0] j;
        logic [7:0] ca;
        logic exp_w;
        int lat, exp_lat;
        j = jdo_addr({1'b0, 8'($urandom)});
        model_cmd(0, j, exp_lat);
        jtag_issue(0, j);
        ca = 8'($urandom);
        address = ca; chipselect = 1'b1; read = 1'b1; write = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_w = (i % 2 == 0);
            vectors++; if (waitrequest !== exp_w) begin miscompares++; $display("FAIL stall_wait[%0d]: got %b want %b", i, waitrequest, exp_w); end
            if (!exp_w) begin
                vectors++; if (readdata !== model_mem[ca]) begin miscompares++; $display("FAIL stall_readdata[%0d]: got %h want %h", i, readdata, model_mem[ca]); end
            end
            step();
        end
        chipselect = 1'b0; read = 1'b0;
        wait_ready(7, lat);
        vectors++; if (lat != exp_lat + 6) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", lat, exp_lat + 6); end
        vectors++; if (MonDReg !== model_dreg) begin miscompares++; $display("FAIL stall_mondreg: got %h want %h", MonDReg, model_dreg); end
    endtask

    task automatic test_region_error();
        logic [37:0] j;
        logic [31:0] saved, d;
        int lat, exp_lat, waits;
        saved = model_mem[3];
        j = jdo_addr(9'h103);
        model_cmd(0, j, exp_lat);
        jtag_run(0, j, lat);
        vectors++; if (lat != exp_lat) begin miscompares++; $display("FAIL region_latency: got %0d want %0d", lat, exp_lat); end
        vectors++; if (MonDReg !== 32'h0) begin miscompares++; $display("FAIL region_mondreg: got %h want 0", MonDReg); end
        vectors++; if (monitor_error !== 1'b1) begin miscompares++; $display("FAIL region_error: got %b want 1", monitor_error); end
        j = jdo_data(~saved);
        model_cmd(2, j, exp_lat);
        jtag_run(2, j, lat);
        vectors++; if (monitor_error !== 1'b1) begin miscompares++; $display("FAIL region_error_sticky: got %b want 1", monitor_error); end
        cpu_read(8'd3, d, waits);
        vectors++; if (d !== saved) begin miscompares++; $display("FAIL region_ram_kept: got %h want %h", d, saved); end
        j = jdo_addr(9'h003);
        model_cmd(0, j, exp_lat);
        jtag_run(0, j, lat);
        vectors++; if (monitor_error !== 1'b0) begin miscompares++; $display("FAIL region_error_clear: got %b want 0", monitor_error); end
        vectors++; if (MonDReg !== saved) begin miscompares++; $display("FAIL region_reread: got %h want %h", MonDReg, saved); end
    endtask

    task automatic test_drop_in_rd_data();
        logic [37:0] j;
        int lat, exp_lat;
        j = jdo_addr({1'b0, 8'($urandom)});
        model_cmd(0, j, exp_lat);
        jtag_issue(0, j);
        step();
        take_no_action_ocimem_a = 1'b1;
        step();
        take_no_action_ocimem_a = 1'b0;
        model_err = 1'b1;
        vectors++; if (monitor_ready !== 1'b1) begin miscompares++; $display("FAIL drop_ready: got %b want 1", monitor_ready); end
        vectors++; if (monitor_error !== 1'b1) begin miscompares++; $display("FAIL drop_error: got %b want 1", monitor_error); end
        vectors++; if (MonDReg !== model_dreg) begin miscompares++; $display("FAIL drop_mondreg: got %h want %h", MonDReg, model_dreg); end
        j = jdo_addr(9'h000);
        model_cmd(1, j, exp_lat);
        jtag_run(1, j, lat);
        vectors++; if (MonDReg !== model_dreg) begin miscompares++; $display("FAIL drop_addr_kept: got %h want %h", MonDReg, model_dreg); end
        vectors++; if (lat != 3) begin miscompares++; $display("FAIL next_latency: got %0d want 3", lat); end
    endtask

    task automatic test_cpu_collision();
        logic [37:0] j;
        logic [31:0] nd;
        logic w;
        int lat, exp_lat;
        nd = $urandom;
        j = jdo_addr(9'h014);
        jtag_issue(0, j);
        cpu_write(8'h14, nd, 4'hF, w);
        model_cpu_write(8'h14, nd, 4'hF);
        model_cmd(0, j, exp_lat);
        wait_ready(2, lat);
        vectors++; if (lat != exp_lat + 1) begin miscompares++; $display("FAIL collide_latency: got %0d want %0d", lat, exp_lat + 1); end
        vectors++; if (MonDReg !== nd) begin miscompares++; $display("FAIL collide_data: got %h want %h", MonDReg, nd); end
    endtask

    task automatic test_reset_pend_wr();
        logic [37:0] j;
        logic [31:0] saved, d;
        int lat, exp_lat, waits;
        j = jdo_addr(9'h00A);
        model_cmd(0, j, exp_lat);
        jtag_run(0, j, lat);
        saved = model_mem[10];
        jtag_issue(2, jdo_data(~saved));
        #1 reset_n = 1'b0;
        #1;
        vectors++; if ({MonDReg, monitor_ready, monitor_error, waitrequest, readdata} !== 67'h0) begin
            miscompares++; $display("FAIL midreset_outputs: got %h/%b/%b/%b/%h want all 0", MonDReg, monitor_ready, monitor_error, waitrequest, readdata); end
        step();
        reset_n = 1'b1;
        model_region = 1'b0; model_word = 8'd0; model_dreg = 32'h0; model_err = 1'b0;
        step();
        vectors++; if (monitor_ready !== 1'b0) begin miscompares++; $display("FAIL postreset_ready: got %b want 0", monitor_ready); end
        cpu_read(8'd10, d, waits);
        vectors++; if (d !== saved) begin miscompares++; $display("FAIL postreset_ram: got %h want %h", d, saved); end
        j = jdo_addr(9'h00A);
        model_cmd(0, j, exp_lat);
        jtag_run(0, j, lat);
        vectors++; if (lat != 3 || MonDReg !== saved) begin miscompares++; $display("FAIL postreset_read: got %0d/%h want 3/%h", lat, MonDReg, saved); end
    endtask

    task automatic test_random();
        logic [37:0] j;
        logic [7:0] a;
        logic [31:0] d;
        logic [3:0] be;
        logic w;
        int kind, lat, exp_lat, waits;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 2) j = jdo_data($urandom);
            else           j = jdo_addr({($urandom_range(0, 5) == 0), 8'($urandom)});
            model_cmd(kind, j, exp_lat);
            jtag_run(kind, j, lat);
            vectors++; if (lat != exp_lat) begin miscompares++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, exp_lat); end
            vectors++; if (MonDReg !== model_dreg) begin miscompares++; $display("FAIL rand_mondreg[%0d]: got %h want %h", n, MonDReg, model_dreg); end
            vectors++; if (monitor_error !== model_err) begin miscompares++; $display("FAIL rand_error[%0d]: got %b want %b", n, monitor_error, model_err); end
            a = 8'($urandom); d = $urandom; be = 4'($urandom);
            cpu_write(a, d, be, w);
            model_cpu_write(a, d, be);
            vectors++; if (w !== 1'b0) begin miscompares++; $display("FAIL rand_wr_wait[%0d]: got %b want 0", n, w); end
            if (n % 2 == 0) a = 8'($urandom);
            cpu_read(a, d, waits);
            vectors++; if (d !== model_mem[a] || waits != 1) begin miscompares++; $display("FAIL rand_cpu_read[%0d]: got %h/%0d want %h/1", n, d, waits, model_mem[a]); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; byteenable = '0;
        test_reset();
        preload();
        test_read_basic();
        test_write_wrap();
        test_cpu_stall();
        test_region_error();
        test_drop_in_rd_data();
        test_cpu_collision();
        test_reset_pend_wr();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
